// File: rtl/dtcm_ctrl_pkg.sv
// Shared widths, FSM state type and counter width for the DTCM controller.
// Optional perf counters are enabled with `define DTCM_CTRL_PERF_CNT_EN.
package dtcm_ctrl_pkg;

   localparam int unsigned DTCM_ADDR_WIDTH = 16;
   localparam int unsigned XLEN            = 32;
   localparam int unsigned DTCM_RAM_AW     = DTCM_ADDR_WIDTH - 2;
   localparam int unsigned PERF_CNT_W      = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RESP = 2'd1,
      ST_HOLD = 2'd2
   } dtcm_state_e;

endpackage

// File: rtl/dtcm_ctrl_perf_cnt.sv
// Free-running, wrapping load/store/stall event counters for dtcm_ctrl.
// Only built when DTCM_CTRL_PERF_CNT_EN is defined.
`ifdef DTCM_CTRL_PERF_CNT_EN
module dtcm_ctrl_perf_cnt
   import dtcm_ctrl_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rd_inc_i,
   input  logic                  wr_inc_i,
   input  logic                  stall_inc_i,
   output logic [PERF_CNT_W-1:0] rd_cnt_o,
   output logic [PERF_CNT_W-1:0] wr_cnt_o,
   output logic [PERF_CNT_W-1:0] stall_cnt_o
);

   logic [PERF_CNT_W-1:0] rd_q, wr_q, stall_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_q    <= '0;
         wr_q    <= '0;
         stall_q <= '0;
      end else begin
         if (rd_inc_i)    rd_q    <= rd_q + PERF_CNT_W'(1);
         if (wr_inc_i)    wr_q    <= wr_q + PERF_CNT_W'(1);
         if (stall_inc_i) stall_q <= stall_q + PERF_CNT_W'(1);
      end
   end

   assign rd_cnt_o    = rd_q;
   assign wr_cnt_o    = wr_q;
   assign stall_cnt_o = stall_q;

endmodule
`endif

// File: rtl/dtcm_ctrl.sv
// LSU-to-DTCM responder: single-port SRAM front end with in-order, held responses.
// Define DTCM_CTRL_PERF_CNT_EN to add perf_rd_cnt/perf_wr_cnt/perf_stall_cnt outputs.
module dtcm_ctrl
   import dtcm_ctrl_pkg::*;
#(
   parameter int unsigned AW     = DTCM_ADDR_WIDTH,
   parameter int unsigned DW     = XLEN,
   parameter int unsigned RAM_AW = AW - 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_read,
   input  logic [AW-1:0]     cmd_addr,
   input  logic [DW-1:0]     cmd_wdata,
   input  logic [DW/8-1:0]   cmd_wmask,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DW-1:0]     rsp_rdata,
   output logic              ram_cs,
   output logic              ram_we,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [DW/8-1:0]   ram_wem,
   output logic [DW-1:0]     ram_din,
   input  logic [DW-1:0]     ram_dout
`ifdef DTCM_CTRL_PERF_CNT_EN
   ,
   output logic [PERF_CNT_W-1:0] perf_rd_cnt,
   output logic [PERF_CNT_W-1:0] perf_wr_cnt,
   output logic [PERF_CNT_W-1:0] perf_stall_cnt
`endif
);

   dtcm_state_e     state_q, state_d;
   logic            rd_q, rd_d;
   logic [DW-1:0]   hold_q, hold_d;
   logic [DW-1:0]   rdata;
   logic            accept;

   logic unused_addr_lsb;
   assign unused_addr_lsb = ^cmd_addr[1:0];

   always_comb begin
      state_d   = state_q;
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      rdata     = '0;
      unique case (state_q)
         ST_IDLE: cmd_ready = rst_n;
         ST_RESP: begin
            rsp_valid = 1'b1;
            rdata     = rd_q ? ram_dout : '0;
            cmd_ready = rst_n & rsp_ready;
         end
         ST_HOLD: begin
            rsp_valid = 1'b1;
            rdata     = hold_q;
            cmd_ready = rst_n & rsp_ready;
         end
         default: ;
      endcase

      accept = cmd_valid & cmd_ready;

      // A held response must retire before a new accept, so accept implies rsp_ready here
      if (state_q == ST_IDLE) begin
         if (accept) state_d = ST_RESP;
      end else if (rsp_ready) begin
         state_d = accept ? ST_RESP : ST_IDLE;
      end else begin
         state_d = ST_HOLD;
      end
   end

   // SRAM output only lives one cycle; freeze it the moment the core stalls
   assign hold_d = (state_q == ST_RESP && !rsp_ready) ? rdata : hold_q;
   assign rd_d   = accept ? cmd_read : rd_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         rd_q    <= 1'b0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         rd_q    <= rd_d;
         hold_q  <= hold_d;
      end
   end

   assign rsp_rdata = rdata;
   assign ram_cs    = accept;
   assign ram_we    = accept & ~cmd_read;
   assign ram_wem   = (accept & ~cmd_read) ? cmd_wmask : '0;
   assign ram_addr  = cmd_addr[AW-1:2];
   assign ram_din   = cmd_wdata;

`ifdef DTCM_CTRL_PERF_CNT_EN
   dtcm_ctrl_perf_cnt u_perf_cnt (
      .clk         (clk),
      .rst_n       (rst_n),
      .rd_inc_i    (accept & cmd_read),
      .wr_inc_i    (accept & ~cmd_read),
      .stall_inc_i (rsp_valid & ~rsp_ready),
      .rd_cnt_o    (perf_rd_cnt),
      .wr_cnt_o    (perf_wr_cnt),
      .stall_cnt_o (perf_stall_cnt)
   );
`endif

endmodule

// File: tb/tb_dtcm_ctrl.sv
// Scoreboard bench for dtcm_ctrl: directed commands, behavioural SRAM, decoupled response monitor.
module tb_dtcm_ctrl;
   import dtcm_ctrl_pkg::*;

   localparam int unsigned AW     = DTCM_ADDR_WIDTH;
   localparam int unsigned DW     = XLEN;
   localparam int unsigned RAM_AW = AW - 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              cmd_valid, cmd_ready, cmd_read;
   logic [AW-1:0]     cmd_addr;
   logic [DW-1:0]     cmd_wdata;
   logic [DW/8-1:0]   cmd_wmask;
   logic              rsp_valid, rsp_ready;
   logic [DW-1:0]     rsp_rdata;
   logic              ram_cs, ram_we;
   logic [RAM_AW-1:0] ram_addr;
   logic [DW/8-1:0]   ram_wem;
   logic [DW-1:0]     ram_din;
   logic [DW-1:0]     ram_dout;
`ifdef DTCM_CTRL_PERF_CNT_EN
   logic [31:0]       perf_rd_cnt, perf_wr_cnt, perf_stall_cnt;
`endif

   always #5 clk = ~clk;

   dtcm_ctrl #(.AW(AW), .DW(DW), .RAM_AW(RAM_AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_read  (cmd_read),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .cmd_wmask (cmd_wmask),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .ram_cs    (ram_cs),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_wem   (ram_wem),
      .ram_din   (ram_din),
      .ram_dout  (ram_dout)
`ifdef DTCM_CTRL_PERF_CNT_EN
      ,
      .perf_rd_cnt    (perf_rd_cnt),
      .perf_wr_cnt    (perf_wr_cnt),
      .perf_stall_cnt (perf_stall_cnt)
`endif
   );

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   logic [31:0] exp_q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] init_val(input logic [RAM_AW-1:0] a);
      return 32'hA500_0000 | 32'(a);
   endfunction

   // Behavioural SRAM (environment), unwritten words read as init_val
   logic [31:0] sram [logic [RAM_AW-1:0]];
   always @(posedge clk) begin
      if (ram_cs) begin
         if (ram_we) begin
            logic [31:0] w;
            w = sram.exists(ram_addr) ? sram[ram_addr] : init_val(ram_addr);
            for (int b = 0; b < 4; b++)
               if (ram_wem[b]) w[8*b +: 8] = ram_din[8*b +: 8];
            sram[ram_addr] = w;
         end else begin
            ram_dout <= sram.exists(ram_addr) ? sram[ram_addr] : init_val(ram_addr);
         end
      end
   end

   // Reference memory, updated by the driver at each accepted store
   logic [31:0] model [logic [RAM_AW-1:0]];

   // Monitor: latency after accept, data/order of every valid cycle, pop on handshake
   logic prev_acc = 1'b0;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_acc = 1'b0;
      end else begin
         if (prev_acc) chk("rsp_latency", 32'(rsp_valid), 32'd1);
         if (rsp_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_rsp", rsp_rdata, 32'hxxxx_xxxx);
            end else begin
               chk("rsp_rdata", rsp_rdata, exp_q[0]);
               if (rsp_ready) void'(exp_q.pop_front());
            end
         end
         prev_acc = cmd_valid & cmd_ready;
      end
   end

   task automatic send(input logic rd, input logic [AW-1:0] addr,
                       input logic [31:0] wd, input logic [3:0] wm);
      int unsigned n = 0;
      logic acc = 1'b0;
      logic [RAM_AW-1:0] wa;
      logic [31:0] w;
      cmd_valid = 1'b1;
      cmd_read  = rd;
      cmd_addr  = addr;
      cmd_wdata = wd;
      cmd_wmask = wm;
      wa = addr[AW-1:2];
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = cmd_ready;
         if (acc) begin
            chk("ram_cs",   32'(ram_cs),   32'd1);
            chk("ram_we",   32'(ram_we),   32'(!rd));
            chk("ram_wem",  32'(ram_wem),  rd ? 32'd0 : 32'(wm));
            chk("ram_addr", 32'(ram_addr), 32'(wa));
         end
         @(posedge clk);
         n++;
      end
      if (!acc) begin
         chk("cmd_accept_timeout", 32'(acc), 32'd1);
      end else begin
         w = model.exists(wa) ? model[wa] : init_val(wa);
         if (rd) begin
            exp_q.push_back(w);
         end else begin
            for (int b = 0; b < 4; b++)
               if (wm[b]) w[8*b +: 8] = wd[8*b +: 8];
            model[wa] = w;
            exp_q.push_back(32'd0);
         end
      end
      #1;
   endtask

   task automatic drain();
      int unsigned n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("drain_outstanding", 32'(exp_q.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      rsp_ready = 1'b1;
      cmd_valid = 1'b1;
      cmd_read  = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      cmd_wmask = '0;

      // reset: command presented but blocked
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("reset_ram_cs",    32'(ram_cs),    32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("post_reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("post_reset_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("post_reset_rsp_rdata", rsp_rdata, 32'd0);
      @(posedge clk); #1;

      // 1: full store then load back-to-back
      send(1'b0, 16'h0010, 32'hDEAD_BEEF, 4'hF);
      send(1'b1, 16'h0010, 32'h0, 4'h0);
      cmd_valid = 1'b0;
      drain();

      // 2: byte-lane merge, plus a zero-mask store that must not alter memory
      send(1'b0, 16'h0010, 32'h0000_00AA, 4'h1);
      send(1'b1, 16'h0010, 32'h0, 4'h0);
      send(1'b0, 16'h0014, 32'h1234_5678, 4'h0);
      send(1'b1, 16'h0014, 32'h0, 4'h0);
      cmd_valid = 1'b0;
      drain();

      // 3: load stalled 3 cycles by the core
      rsp_ready = 1'b0;
      send(1'b1, 16'h0010, 32'h0, 4'h0);
      cmd_valid = 1'b1;
      cmd_read  = 1'b1;
      cmd_addr  = 16'h0008;
      repeat (3) begin
         @(negedge clk);
         chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
         chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("release_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("release_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("release_outstanding", 32'(exp_q.size()), 32'd0);
      @(posedge clk); #1;

      // 4: eight back-to-back loads
      for (int i = 0; i < 8; i++)
         send(1'b1, 16'(4 * i), 32'h0, 4'h0);
      cmd_valid = 1'b0;
      drain();

      // 5: reset while holding a response
      rsp_ready = 1'b0;
      send(1'b1, 16'h0010, 32'h0, 4'h0);
      cmd_valid = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("pre_reset_hold_valid", 32'(rsp_valid), 32'd1);
      @(posedge clk); #1;
      rst_n     = 1'b0;
      cmd_valid = 1'b1;
      cmd_read  = 1'b0;
      cmd_wmask = 4'hF;
      @(negedge clk);
      chk("midreset_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("midreset_ram_cs",    32'(ram_cs),    32'd0);
      exp_q.delete();
      @(posedge clk); #1;
      rst_n     = 1'b1;
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("after_reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("after_reset_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("after_reset_rsp_rdata", rsp_rdata, 32'd0);
      @(posedge clk); #1;

`ifdef DTCM_CTRL_PERF_CNT_EN
      // 6: 2 stores, 3 loads, 4 stall cycles since the last reset
      send(1'b0, 16'h0020, 32'h1111_2222, 4'hF);
      send(1'b0, 16'h0024, 32'h3333_4444, 4'h3);
      send(1'b1, 16'h0020, 32'h0, 4'h0);
      send(1'b1, 16'h0024, 32'h0, 4'h0);
      cmd_valid = 1'b0;
      drain();
      rsp_ready = 1'b0;
      send(1'b1, 16'h0010, 32'h0, 4'h0);
      cmd_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      drain();
      @(negedge clk);
      chk("perf_rd_cnt",    perf_rd_cnt,    32'd3);
      chk("perf_wr_cnt",    perf_wr_cnt,    32'd2);
      chk("perf_stall_cnt", perf_stall_cnt, 32'd4);
`endif

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
